// File: rtl/noc_pkg.sv
// Shared definitions for the NoC input port: port-select codes, flit field
// layout, FSM state encoding and the XY route function.
package noc_pkg;

  // Flit layout: [15:12] dest X, [11:8] dest Y, [7:0] payload
  localparam int FLIT_W    = 16;
  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 8;
  localparam int DX_LSB    = 12;
  localparam int DY_LSB    = 8;
  localparam int PL_LSB    = 0;
  localparam int SEL_W     = 3;

  // Output port select codes toward the 1-to-5 demux
  localparam logic [SEL_W-1:0] PORT_N = 3'b000;
  localparam logic [SEL_W-1:0] PORT_S = 3'b001;
  localparam logic [SEL_W-1:0] PORT_W = 3'b010;
  localparam logic [SEL_W-1:0] PORT_E = 3'b011;
  localparam logic [SEL_W-1:0] PORT_L = 3'b100;

  // Input port control FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally
  function automatic logic [SEL_W-1:0] xy_route(
    input logic [FLIT_W-1:0]  flit,
    input logic [COORD_W-1:0] x_id,
    input logic [COORD_W-1:0] y_id
  );
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = flit[DX_LSB +: COORD_W];
    dy = flit[DY_LSB +: COORD_W];
    if (dx > x_id)      xy_route = PORT_E;
    else if (dx < x_id) xy_route = PORT_W;
    else if (dy > y_id) xy_route = PORT_N;
    else if (dy < y_id) xy_route = PORT_S;
    else                xy_route = PORT_L;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Flit FIFO for the input port. Power-of-two depth so pointers wrap naturally.
// Storage is not reset; only pointers and occupancy are.
module noc_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FLIT_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == DEPTH_C);
  assign empty_o = (count == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];
  assign count_o = count;

  // Flit storage write
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/noc_input_port.sv
// NoC router input port: buffers incoming flits, computes the XY output port
// for the head flit, and presents it to the crossbar until granted.
module noc_input_port
  import noc_pkg::*;
#(
  parameter logic [COORD_W-1:0] X_ID  = 4'd0,
  parameter logic [COORD_W-1:0] Y_ID  = 4'd0,
  parameter int                 DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [FLIT_W-1:0]      data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   grant_i,
  output logic [FLIT_W-1:0]      data_o,
  output logic [SEL_W-1:0]       sel_o,
  output logic                   enable_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [FLIT_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // ready depends only on occupancy, so a full FIFO never accepts even when popping
  assign ready_o  = ~full;
  assign push     = valid_i & ready_o;
  assign enable_o = (state_q == ST_SEND);
  assign pop      = enable_o & grant_i;
  assign count_o  = count;
  assign data_o   = enable_o ? head  : '0;
  assign sel_o    = enable_o ? sel_q : '0;

  noc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (data_i),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Control FSM: ROUTE always sits between flits so sel is registered from the new head
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty) state_q <= ST_ROUTE;
        end
        ST_ROUTE: begin
          sel_q   <= xy_route(head, X_ID, Y_ID);
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (grant_i) begin
            if (count > CNT_W'(1)) state_q <= ST_ROUTE;
            else                   state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/noc_input_port.md
NOC_INPUT_PORT -- requirements
Module: noc_input_port

Interface
REQ-001 SHALL have parameter X_ID, default 0, 4-bit X coordinate of this router.
REQ-002 SHALL have parameter Y_ID, default 0, 4-bit Y coordinate of this router.
REQ-003 SHALL have parameter DEPTH, default 4, FIFO depth in flits; power of two, at least 2.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports listed below.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 data_i  input  16  incoming flit: [15:12] dest X, [11:8] dest Y, [7:0] payload.
REQ-008 valid_i  input  1  upstream flit valid.
REQ-009 ready_o  output  1  FIFO can accept a flit.
REQ-010 grant_i  input  1  crossbar/arbiter accepts the flit presented this cycle.
REQ-011 data_o  output  16  head flit toward the 1-to-5 demux.
REQ-012 sel_o  output  3  output port: 000 N, 001 S, 010 W, 011 E, 100 L.
REQ-013 enable_o  output  1  data_o/sel_o valid; drives the demux enable.
REQ-014 count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL store data_i on a rising edge when valid_i and ready_o are both 1; ready_o = (count < DEPTH), combinational from count only.
REQ-016 SHALL pop the head flit on a rising edge when enable_o and grant_i are both 1; grant_i is ignored while enable_o is 0.
REQ-017 Simultaneous push and pop SHALL leave count unchanged. When full, ready_o is 0, so no push occurs, even if a pop happens in the same cycle.
REQ-018 SHALL preserve FIFO order; pointers wrap modulo DEPTH.
REQ-019 SHALL implement the FSM IDLE -> ROUTE -> SEND.
- IDLE: go to ROUTE when count != 0.
- ROUTE: register sel from the head flit, then go to SEND.
- SEND: hold; on grant_i, go to ROUTE if count > 1 before the pop, otherwise go to IDLE.
REQ-020 Route computation SHALL be XY order, unsigned 4-bit compares:
- dest X > X_ID -> E
- dest X < X_ID -> W
- else dest Y > Y_ID -> N
- else dest Y < Y_ID -> S
- else L
REQ-021 enable_o SHALL be 1 exactly while the FSM is in SEND.
REQ-022 data_o SHALL equal the head flit and sel_o the registered sel while enable_o = 1; both SHALL be 0 when enable_o = 0 (never X or Z).
REQ-023 Latency: a flit accepted at edge k into an empty FIFO in IDLE SHALL see enable_o = 1 after edge k+2.
REQ-024 data_o and sel_o SHALL stay stable throughout SEND until grant_i.
REQ-025 Peak throughput SHALL be one flit per 2 cycles: ROUTE is always re-entered between flits.

Reset
REQ-026 rst_i = 1 SHALL immediately, without a clock edge, force the following; FIFO contents are discarded:
- FSM to IDLE
- pointers and count to 0
- sel register to 0
- enable_o = 0, data_o = 0, sel_o = 0, ready_o = 1, count_o = 0
REQ-027 Reset asserted mid-SEND SHALL drop the pending flit; no pop is counted and no grant_i is honoured while rst_i = 1.

Structure
REQ-028 A shared package noc_pkg SHALL hold:
- port-select constants PORT_N/S/W/E/L
- flit field positions and widths
- the FSM state enum
REQ-029 FIFO storage SHALL be a sub-module noc_fifo (parameter DEPTH, WIDTH = 16, push/pop/full/empty/count); route logic and FSM live in noc_input_port.

Verification (X_ID = 1, Y_ID = 1, DEPTH = 4)
REQ-030 Assert rst_i during SEND with 3 flits queued -> same cycle: enable_o = 0, count_o = 0, ready_o = 1, data_o = 0.
REQ-031 Push 16'h2155 at edge k, grant_i = 0 -> after edge k+2: enable_o = 1, sel_o = 011, data_o = 16'h2155, held 5 cycles until grant_i, then enable_o = 0.
REQ-032 Route table -> expected sel_o, with immediate grant:
- 16'h1134 -> 100 (L)
- 16'h0100 -> 010 (W)
- 16'h1200 -> 000 (N)
- 16'h1000 -> 001 (S)
REQ-033 grant_i = 0, push 16'h2001, 16'h2002, 16'h2003, 16'h2004 -> ready_o = 0 and count_o = 4; a 5th valid_i is not stored. Then grant_i = 1 -> flits emerge 2001, 2002, 2003, 2004, one every 2 cycles.
REQ-034 count_o = 2 with push and grant on the same edge -> count_o stays 2. grant_i = 1 while enable_o = 0 -> count_o unchanged.
